// File: rtl/uart_tx_framer.sv
// uart_tx_framer: parametrised UART transmitter fed by a small push-side FIFO.
// A frame is one start bit (0), DATA_BITS data bits LSB first, an optional
// odd/even parity bit and STOP_BITS stop bits (1); every bit lasts DIV clocks.
// Queued words go out back-to-back with no idle cycle between frames.
module uart_tx_framer #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 bit_end;
  logic                 last_stop_end;
  logic                 push;
  logic                 pop;

  // The full test uses the registered count, so a push against a full FIFO
  // is refused even when a pop frees a slot in that same cycle.
  assign wr_ready = (fifo_count != FIFO_FULL);
  assign push     = wr_valid && wr_ready;

  assign head     = mem[rd_ptr];
  assign head_par = (PARITY == 1) ? ~(^head) : (^head);

  assign bit_end       = (baud_cnt == BAUD_LAST);
  assign last_stop_end = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
  assign pop           = (fifo_count != '0) && ((state == S_IDLE) || last_stop_end);

  assign busy = (state != S_IDLE);

  // FIFO storage; only written on an accepted push, so later wr_data changes are ignored.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Baud timer: restarts at every bit boundary and rests at zero while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
    end else if (state == S_IDLE || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // Frame sequencer; tx is registered and changes on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state     <= S_START;
            tx        <= 1'b0;
            shift_reg <= head;
            par_bit   <= head_par;
          end
        end
        S_START: begin
          if (bit_end) begin
            state     <= S_DATA;
            bit_cnt   <= '0;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state   <= S_STOP;
            bit_cnt <= '0;
            tx      <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (pop) begin
                state     <= S_START;
                tx        <= 1'b0;
                shift_reg <= head;
                par_bit   <= head_par;
              end else begin
                state <= S_IDLE;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: randomized bench for uart_tx_framer. Expected line
// waveforms come from a frame model built from the word, data width, parity
// mode and stop count, compared cycle by cycle against tx and busy.
module tb_uart_tx_framer;

  // Instance 0: 8N2 DIV=4, 1: defaults (DIV=5208), 2: 7E1 DIV=4, 3: 7O1 DIV=4
  localparam int DIV_K [4] = '{4, 5208, 4, 4};
  localparam int DB_K  [4] = '{8, 8, 7, 7};
  localparam int PAR_K [4] = '{0, 0, 2, 1};
  localparam int SB_K  [4] = '{2, 2, 1, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wr_data_a = '0, wr_data_d = '0;
  logic [6:0] wr_data_p = '0, wr_data_o = '0;
  logic       wr_valid_a = 1'b0, wr_valid_d = 1'b0, wr_valid_p = 1'b0, wr_valid_o = 1'b0;
  logic       wr_ready_a, wr_ready_d, wr_ready_p, wr_ready_o;
  logic       tx_a, tx_d, tx_p, tx_o;
  logic       busy_a, busy_d, busy_p, busy_o;
  logic [2:0] fifo_count_a, fifo_count_d, fifo_count_p, fifo_count_o;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic [8:0] exp_q [4][$];
  logic [8:0] drv_q [4][$];
  int gap_log [4][16];

  uart_tx_framer #(.CLK_HZ(40), .BAUD(10)) dut_a (
    .clk(clk), .reset(reset), .wr_data(wr_data_a), .wr_valid(wr_valid_a), .wr_ready(wr_ready_a),
    .tx(tx_a), .busy(busy_a), .fifo_count(fifo_count_a));

  uart_tx_framer dut_d (
    .clk(clk), .reset(reset), .wr_data(wr_data_d), .wr_valid(wr_valid_d), .wr_ready(wr_ready_d),
    .tx(tx_d), .busy(busy_d), .fifo_count(fifo_count_d));

  uart_tx_framer #(.CLK_HZ(40), .BAUD(10), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_p (
    .clk(clk), .reset(reset), .wr_data(wr_data_p), .wr_valid(wr_valid_p), .wr_ready(wr_ready_p),
    .tx(tx_p), .busy(busy_p), .fifo_count(fifo_count_p));

  uart_tx_framer #(.CLK_HZ(40), .BAUD(10), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .reset(reset), .wr_data(wr_data_o), .wr_valid(wr_valid_o), .wr_ready(wr_ready_o),
    .tx(tx_o), .busy(busy_o), .fifo_count(fifo_count_o));

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always ends even if a bounded wait is miscounted
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion before 2000000");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic tx_of(input int k);
    case (k)
      0: return tx_a;
      1: return tx_d;
      2: return tx_p;
      default: return tx_o;
    endcase
  endfunction

  function automatic logic busy_of(input int k);
    case (k)
      0: return busy_a;
      1: return busy_d;
      2: return busy_p;
      default: return busy_o;
    endcase
  endfunction

  function automatic logic ready_of(input int k);
    case (k)
      0: return wr_ready_a;
      1: return wr_ready_d;
      2: return wr_ready_p;
      default: return wr_ready_o;
    endcase
  endfunction

  // Reference frame: start 0, data LSB first, parity from the ones count, stop 1s
  function automatic void model_frame(input logic [8:0] w, input int db, input int par, input int sb,
                                      output logic [15:0] fr, output int len);
    int ones;
    ones = 0;
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      fr[1 + i] = w[i];
      ones += int'(w[i]);
    end
    len = 1 + db;
    if (par != 0) begin
      fr[len] = (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      len++;
    end
    len += sb;
  endfunction

  function automatic void queue_word(input int k, input logic [8:0] w);
    logic [8:0] m;
    m = w & 9'((1 << DB_K[k]) - 1);
    exp_q[k].push_back(m);
    drv_q[k].push_back(m);
  endfunction

  task automatic set_in(input int k, input logic [8:0] w, input logic v);
    case (k)
      0: begin wr_data_a = w[7:0]; wr_valid_a = v; end
      1: begin wr_data_d = w[7:0]; wr_valid_d = v; end
      2: begin wr_data_p = w[6:0]; wr_valid_p = v; end
      default: begin wr_data_o = w[6:0]; wr_valid_o = v; end
    endcase
  endtask

  // Push every word of drv_q[k], honouring wr_ready, with random idle gaps
  task automatic drive(input int k, input int max_gap);
    logic [8:0] w;
    int guard;
    while (drv_q[k].size() > 0) begin
      w = drv_q[k].pop_front();
      set_in(k, w, 1'b1);
      guard = 0;
      while (ready_of(k) !== 1'b1 && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
      set_in(k, 9'($urandom), 1'b0);
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  // Follow instance k's line and compare each expected frame cycle by cycle
  task automatic check_stream(input int k, input string name);
    logic [8:0]  w;
    logic [15:0] fr;
    int len, gap, bad, idx, div;
    div = DIV_K[k];
    idx = 0;
    while (exp_q[k].size() > 0) begin
      w = exp_q[k].pop_front();
      model_frame(w, DB_K[k], PAR_K[k], SB_K[k], fr, len);
      gap = 0;
      while (tx_of(k) !== 1'b0 && gap < 400) begin
        @(negedge clk);
        gap++;
      end
      if (idx < 16) gap_log[k][idx] = gap;
      checks++;
      if (tx_of(k) !== 1'b0) begin
        $display("[TB] FAIL %s start%0d: tx=%b after %0d clocks, required start bit 0", name, idx, tx_of(k), gap);
        exp_q[k].delete();
        return;
      end
      passes++;
      bad = 0;
      for (int c = 0; c < len * div; c++) begin
        if (c > 0) @(negedge clk);
        if (tx_of(k) !== fr[c / div] || busy_of(k) !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0)
        $display("[TB] FAIL %s frame%0d word=%h: %0d of %0d cycles differ in tx/busy, required 0", name, idx, w, bad, len * div);
      else
        passes++;
      idx++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    checks++; if (tx_a !== 1'b1) $display("[TB] FAIL reset_tx: got %b, required 1", tx_a); else passes++;
    checks++; if (busy_a !== 1'b0) $display("[TB] FAIL reset_busy: got %b, required 0", busy_a); else passes++;
    checks++; if (fifo_count_a !== 3'd0) $display("[TB] FAIL reset_count: got %0d, required 0", fifo_count_a); else passes++;
    checks++; if (wr_ready_a !== 1'b1) $display("[TB] FAIL reset_ready: got %b, required 1", wr_ready_a); else passes++;
    checks++; if (tx_d !== 1'b1 || tx_p !== 1'b1 || tx_o !== 1'b1)
      $display("[TB] FAIL reset_tx_all: got %b%b%b, required 111", tx_d, tx_p, tx_o); else passes++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0)
      $display("[TB] FAIL idle_after_reset: tx=%b busy=%b, required tx=1 busy=0", tx_a, busy_a); else passes++;
  endtask

  task automatic test_default;
    exp_q[1].push_back(9'h013);
    @(negedge clk);
    wr_data_d = 8'h13;
    wr_valid_d = 1'b1;
    @(negedge clk);
    wr_valid_d = 1'b0;
    wr_data_d = 8'($urandom);
    check_stream(1, "default_13");
    checks++; if (gap_log[1][0] != 1)
      $display("[TB] FAIL default_latency: start after %0d clocks, required 1", gap_log[1][0]); else passes++;
    checks++; if (busy_d !== 1'b0)
      $display("[TB] FAIL default_busy_drop: busy=%b after frame, required 0", busy_d); else passes++;
  endtask

  task automatic test_burst;
    logic [8:0] sw [5];
    int t0;
    sw = '{9'h000, 9'h013, 9'h013, 9'h0FA, 9'h0FA};
    for (int i = 0; i < 5; i++) queue_word(0, sw[i]);
    @(negedge clk);
    fork
      begin
        t0 = cyc;
        drive(0, 0);
        checks++; if (cyc - t0 != 5)
          $display("[TB] FAIL burst_no_stall: %0d clocks to push, required 5", cyc - t0); else passes++;
        checks++; if (fifo_count_a !== 3'd4)
          $display("[TB] FAIL burst_count: got %0d, required 4", fifo_count_a); else passes++;
        checks++; if (wr_ready_a !== 1'b0)
          $display("[TB] FAIL burst_ready: got %b, required 0", wr_ready_a); else passes++;
      end
      check_stream(0, "burst_spec");
    join
    for (int i = 1; i < 5; i++) begin
      checks++; if (gap_log[0][i] != 0)
        $display("[TB] FAIL burst_gap%0d: %0d idle clocks, required 0", i, gap_log[0][i]); else passes++;
    end
    checks++; if (busy_a !== 1'b0) $display("[TB] FAIL burst_end_busy: got %b, required 0", busy_a); else passes++;
    for (int i = 0; i < 8; i++) queue_word(0, 9'($urandom));
    fork
      drive(0, 2);
      check_stream(0, "burst_rand");
    join
    checks++; if (busy_a !== 1'b0) $display("[TB] FAIL burst_rand_busy: got %b, required 0", busy_a); else passes++;
  endtask

  task automatic test_parity;
    queue_word(2, 9'h055);
    queue_word(2, 9'h054);
    queue_word(3, 9'h055);
    queue_word(3, 9'h054);
    for (int i = 0; i < 4; i++) begin
      queue_word(2, 9'($urandom));
      queue_word(3, 9'($urandom));
    end
    @(negedge clk);
    fork
      drive(2, 3);
      drive(3, 3);
      check_stream(2, "parity_even");
      check_stream(3, "parity_odd");
    join
    checks++; if (busy_p !== 1'b0 || busy_o !== 1'b0)
      $display("[TB] FAIL parity_busy: got %b%b, required 00", busy_p, busy_o); else passes++;
  endtask

  task automatic test_reset_midframe;
    logic [8:0] wa;
    int g, bad;
    wa = 9'h0A5;
    @(negedge clk);
    set_in(0, wa, 1'b1);
    @(negedge clk);
    set_in(0, 9'h000, 1'b0);
    g = 0;
    while (tx_a !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    set_in(0, 9'h03C, 1'b1);
    @(negedge clk);
    set_in(0, 9'h0FF, 1'b1);
    @(negedge clk);
    set_in(0, 9'h000, 1'b0);
    repeat (DIV_K[0] * 4 - 1) @(negedge clk);
    checks++; if (tx_a !== wa[3])
      $display("[TB] FAIL midframe_bit3: tx=%b, required %b", tx_a, wa[3]); else passes++;
    checks++; if (fifo_count_a !== 3'd2)
      $display("[TB] FAIL midframe_count: got %0d, required 2", fifo_count_a); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (tx_a !== 1'b1) $display("[TB] FAIL abort_tx: got %b, required 1", tx_a); else passes++;
    checks++; if (busy_a !== 1'b0) $display("[TB] FAIL abort_busy: got %b, required 0", busy_a); else passes++;
    checks++; if (fifo_count_a !== 3'd0) $display("[TB] FAIL abort_count: got %0d, required 0", fifo_count_a); else passes++;
    checks++; if (wr_ready_a !== 1'b1) $display("[TB] FAIL abort_ready: got %b, required 1", wr_ready_a); else passes++;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0)
      $display("[TB] FAIL abort_quiet: %0d active cycles after release, required 0", bad); else passes++;
  endtask

  task automatic test_full_push_pop;
    logic [8:0]  ws [6];
    logic [15:0] fr;
    int len, g;
    for (int i = 0; i < 6; i++) begin
      ws[i] = 9'($urandom) & 9'h0FF;
      exp_q[0].push_back(ws[i]);
    end
    model_frame(ws[0], DB_K[0], PAR_K[0], SB_K[0], fr, len);
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          set_in(0, ws[i], 1'b1);
          @(negedge clk);
        end
        set_in(0, ws[5], 1'b1);
        checks++; if (fifo_count_a !== 3'd4)
          $display("[TB] FAIL full_fill: count %0d, required 4", fifo_count_a); else passes++;
        g = 0;
        while (fifo_count_a === 3'd4 && g < 200) begin
          @(negedge clk);
          g++;
        end
        checks++; if (g != len * DIV_K[0] - 3)
          $display("[TB] FAIL full_pop_time: pop after %0d clocks, required %0d", g, len * DIV_K[0] - 3); else passes++;
        checks++; if (fifo_count_a !== 3'd3)
          $display("[TB] FAIL full_pushpop_count: got %0d, required 3", fifo_count_a); else passes++;
        checks++; if (wr_ready_a !== 1'b1)
          $display("[TB] FAIL full_pushpop_ready: got %b, required 1", wr_ready_a); else passes++;
        @(negedge clk);
        checks++; if (fifo_count_a !== 3'd4)
          $display("[TB] FAIL full_retry_count: got %0d, required 4", fifo_count_a); else passes++;
        set_in(0, 9'($urandom), 1'b0);
      end
      check_stream(0, "full_pushpop");
    join
    checks++; if (busy_a !== 1'b0)
      $display("[TB] FAIL full_no_duplicate: busy=%b after 6 frames, required 0", busy_a); else passes++;
  endtask

  task automatic test_last_stop_push;
    logic [8:0]  w1, w2;
    logic [15:0] fr;
    int len, g;
    w1 = 9'($urandom) & 9'h0FF;
    w2 = 9'($urandom) & 9'h0FF;
    exp_q[0].push_back(w1);
    exp_q[0].push_back(w2);
    model_frame(w1, DB_K[0], PAR_K[0], SB_K[0], fr, len);
    @(negedge clk);
    fork
      begin
        set_in(0, w1, 1'b1);
        @(negedge clk);
        set_in(0, 9'($urandom), 1'b0);
        g = 0;
        while (tx_a !== 1'b0 && g < 100) begin
          @(negedge clk);
          g++;
        end
        repeat (len * DIV_K[0] - 1) @(negedge clk);
        set_in(0, w2, 1'b1);
        @(negedge clk);
        set_in(0, 9'($urandom), 1'b0);
        checks++; if (busy_a !== 1'b0 || tx_a !== 1'b1)
          $display("[TB] FAIL late_idle: busy=%b tx=%b, required busy=0 tx=1", busy_a, tx_a); else passes++;
        checks++; if (fifo_count_a !== 3'd1)
          $display("[TB] FAIL late_count: got %0d, required 1", fifo_count_a); else passes++;
      end
      check_stream(0, "late_push");
    join
    checks++; if (gap_log[0][1] != 1)
      $display("[TB] FAIL late_gap: %0d idle clocks, required 1", gap_log[0][1]); else passes++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) queue_word(0, 9'($urandom));
    @(negedge clk);
    fork
      drive(0, 60);
      check_stream(0, "random");
    join
    checks++; if (busy_a !== 1'b0) $display("[TB] FAIL random_busy: got %b, required 0", busy_a); else passes++;
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_default();
    test_burst();
    test_parity();
    test_reset_midframe();
    test_full_push_pop();
    test_last_stop_push();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
